ace_tape_player: RTL and testbench

Tape-playback waveform generator for the Jupiter Ace core. It is the other end of the cassette path: the machine's ROM loader decodes the `ear` input, and this block produces that signal from a byte stream (a RAM/SD tape image reader upstream). It emits, in order, a leader tone, a sync pulse, MSB-first data bits and a tail pulse, using the Ace pulse-length encoding. Its `ear` output drives the `ear` input of the Ace top level in place of the physical cassette pin.

---
 rtl/ace_tape_player.sv | 206 ++++++++++++++++++++
 tb/tb_ace_tape_player.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ace_tape_player.sv
// ace_tape_player -- cassette playback waveform generator for the Jupiter Ace.
//
// Converts a byte stream into the Ace tape pulse encoding on `ear`. Each block
// is a leader tone, a sync pulse, MSB-first data bits and a closing tail
// pulse. Every symbol is `ear`=1 for H cycles followed by `ear`=0 for L cycles.
//
// Ports:
//   clk         single clock (clk65 domain)
//   reset       synchronous, active-high
//   start       one-cycle request to begin a block (ignored while busy)
//   stop        synchronous abort back to IDLE, discards the byte in progress
//   data        tape byte
//   data_valid  data / data_last are valid
//   data_last   marks the final byte of the block
//   data_ready  a byte is accepted this cycle when data_valid is also high
//   ear         generated tape waveform (registered)
//   busy        high in every state except IDLE
//   done        one-cycle pulse after the tail completes
module ace_tape_player #(
  parameter int unsigned LEADER_HALF  = 1300,
  parameter int unsigned LEADER_COUNT = 4096,
  parameter int unsigned SYNC_HI      = 390,
  parameter int unsigned SYNC_LO      = 460,
  parameter int unsigned BIT0_HALF    = 1040,
  parameter int unsigned BIT1_HALF    = 2080,
  parameter int unsigned TAIL_HALF    = 1040
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] data,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       ear,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEADER, S_SYNC, S_FETCH, S_BIT, S_TAIL
  } state_t;

  // Half-period reload values: the counter runs N-1 down to 0, i.e. N cycles.
  localparam logic [15:0] LEADER_L  = 16'(LEADER_HALF - 1);
  localparam logic [15:0] LCOUNT_L  = 16'(LEADER_COUNT - 1);
  localparam logic [15:0] SYNC_HI_L = 16'(SYNC_HI - 1);
  localparam logic [15:0] SYNC_LO_L = 16'(SYNC_LO - 1);
  localparam logic [15:0] BIT0_L    = 16'(BIT0_HALF - 1);
  localparam logic [15:0] BIT1_L    = 16'(BIT1_HALF - 1);
  localparam logic [15:0] TAIL_L    = 16'(TAIL_HALF - 1);

  state_t      state_q, state_d;
  logic [15:0] half_q, half_d;    // cycles left in the current half, minus one
  logic [15:0] lcnt_q, lcnt_d;    // leader cycles still to emit after this one
  logic [2:0]  bit_q, bit_d;      // bits still to emit after the current one
  logic [7:0]  shreg_q, shreg_d;  // current bit is always shreg_q[7]
  logic        last_q, last_d;
  logic        ear_q, ear_d;
  logic        done_q, done_d;

  logic half_end;
  logic accept;

  function automatic logic [15:0] bit_len(input logic b);
    return b ? BIT1_L : BIT0_L;
  endfunction

  assign half_end   = (half_q == 16'd0);
  assign data_ready = (state_q == S_FETCH) && !stop && !reset;
  assign accept     = data_ready && data_valid;

  assign ear  = ear_q;
  assign done = done_q;
  assign busy = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    half_d  = half_q;
    lcnt_d  = lcnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    ear_d   = ear_q;
    done_d  = 1'b0;

    // Mid-half in any symbol state: just count down.
    if (!half_end && state_q inside {S_LEADER, S_SYNC, S_BIT, S_TAIL}) begin
      half_d = half_q - 16'd1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          ear_d = 1'b0;
          if (start) begin
            state_d = S_LEADER;
            ear_d   = 1'b1;
            half_d  = LEADER_L;
            lcnt_d  = LCOUNT_L;
          end
        end
        S_LEADER: begin
          if (ear_q) begin
            ear_d  = 1'b0;
            half_d = LEADER_L;
          end else if (lcnt_q != 16'd0) begin
            lcnt_d = lcnt_q - 16'd1;
            ear_d  = 1'b1;
            half_d = LEADER_L;
          end else begin
            state_d = S_SYNC;
            ear_d   = 1'b1;
            half_d  = SYNC_HI_L;
          end
        end
        S_SYNC: begin
          if (ear_q) begin
            ear_d  = 1'b0;
            half_d = SYNC_LO_L;
          end else begin
            state_d = S_FETCH;
            ear_d   = 1'b0;
          end
        end
        S_FETCH: begin
          // Underrun simply stalls here with ear low.
          if (accept) begin
            state_d = S_BIT;
            shreg_d = data;
            last_d  = data_last;
            bit_d   = 3'd7;
            ear_d   = 1'b1;
            half_d  = bit_len(data[7]);
          end
        end
        S_BIT: begin
          if (ear_q) begin
            ear_d  = 1'b0;
            half_d = bit_len(shreg_q[7]);
          end else if (bit_q != 3'd0) begin
            bit_d   = bit_q - 3'd1;
            shreg_d = {shreg_q[6:0], 1'b0};
            ear_d   = 1'b1;
            half_d  = bit_len(shreg_q[6]);
          end else if (last_q) begin
            state_d = S_TAIL;
            ear_d   = 1'b1;
            half_d  = TAIL_L;
          end else begin
            state_d = S_FETCH;
            ear_d   = 1'b0;
          end
        end
        S_TAIL: begin
          if (ear_q) begin
            ear_d  = 1'b0;
            half_d = TAIL_L;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Abort wins over everything, including a start on the same cycle.
    if (stop) begin
      state_d = S_IDLE;
      half_d  = 16'd0;
      lcnt_d  = 16'd0;
      bit_d   = 3'd0;
      shreg_d = 8'd0;
      last_d  = 1'b0;
      ear_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      half_q  <= 16'd0;
      lcnt_q  <= 16'd0;
      bit_q   <= 3'd0;
      shreg_q <= 8'd0;
      last_q  <= 1'b0;
      ear_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      lcnt_q  <= lcnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      ear_q   <= ear_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_ace_tape_player.sv
// Testbench for ace_tape_player. A reference model expands each block (bytes
// plus per-byte data_valid delays) into an expected per-cycle timeline of
// ear/busy/data_ready/done, which is replayed against the DUT cycle by cycle.
module tb_ace_tape_player;

  localparam int LH = 4, LC = 3, SH = 2, SL = 3, B0 = 2, B1 = 5, TH = 3;

  logic       clk = 1'b0;
  logic       reset, start, stop;
  logic [7:0] data;
  logic       data_valid, data_last;
  logic       data_ready, ear, busy, done;

  ace_tape_player #(
    .LEADER_HALF(LH), .LEADER_COUNT(LC), .SYNC_HI(SH), .SYNC_LO(SL),
    .BIT0_HALF(B0), .BIT1_HALF(B1), .TAIL_HALF(TH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .data(data), .data_valid(data_valid), .data_last(data_last),
    .data_ready(data_ready), .ear(ear), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One expected cycle after the start edge.
  typedef struct packed {
    logic       e;    // ear
    logic       r;    // data_ready
    logic       b;    // busy
    logic       d;    // done
    logic       v;    // data_valid to drive (only meaningful when r)
    logic       l;    // data_last to drive on the accept cycle
    logic [7:0] dat;  // byte to drive on the accept cycle
  } cyc_t;

  cyc_t       tl[$];
  logic [7:0] blk_bytes[$];
  int         blk_dly[$];
  int         bit3_idx;

  function automatic void push(input logic e, r, b, d, v, l, input logic [7:0] dat);
    cyc_t c;
    c = '{e: e, r: r, b: b, d: d, v: v, l: l, dat: dat};
    tl.push_back(c);
  endfunction

  function automatic void sym(input int h, input int lo);
    repeat (h)  push(1, 0, 1, 0, 0, 0, 8'h00);
    repeat (lo) push(0, 0, 1, 0, 0, 0, 8'h00);
  endfunction

  // Expected waveform of a whole block, straight from the symbol rules.
  function automatic void build();
    logic [7:0] byt;
    int         h;
    tl.delete();
    bit3_idx = -1;
    repeat (LC) sym(LH, LH);
    sym(SH, SL);
    foreach (blk_bytes[i]) begin
      byt = blk_bytes[i];
      repeat (blk_dly[i]) push(0, 1, 1, 0, 0, 0, 8'h00);
      push(0, 1, 1, 0, 1, (i == blk_bytes.size() - 1), byt);
      for (int k = 7; k >= 0; k--) begin
        h = byt[k] ? B1 : B0;
        if (i == 0 && k == 3) bit3_idx = tl.size();
        sym(h, h);
      end
    end
    sym(TH, TH);
    push(0, 0, 0, 1, 0, 0, 8'h00);
  endfunction

  task automatic kick();
    @(posedge clk); #1;
    start      = 1'b1;
    stop       = 1'b0;
    data_valid = 1'($urandom_range(0, 1));
    data       = 8'($urandom);
  endtask

  // Replay the timeline. stop_at >= 0 aborts on that cycle (stop or reset).
  task automatic run(input int stop_at, input bit use_reset, input bit start_noise, input bit chain);
    cyc_t c;
    for (int i = 0; i < tl.size(); i++) begin
      @(posedge clk); #1;
      c = tl[i];
      start = 1'b0;
      if (start_noise && c.b && $urandom_range(0, 5) == 0) start = 1'b1;
      if (chain && i == tl.size() - 1) start = 1'b1;
      if (c.r) begin
        data_valid = c.v;
        data       = c.v ? c.dat : 8'($urandom);
        data_last  = c.v ? c.l : 1'($urandom_range(0, 1));
      end else begin
        data_valid = 1'($urandom_range(0, 1));
        data       = 8'($urandom);
        data_last  = 1'($urandom_range(0, 1));
      end
      if (i == stop_at) begin
        if (use_reset) reset = 1'b1;
        else           stop  = 1'b1;
      end
      #1;
      check($sformatf("ear@%0d", i), ear, c.e);
      check($sformatf("busy@%0d", i), busy, c.b);
      check($sformatf("ready@%0d", i), data_ready, (i == stop_at) ? 1'b0 : c.r);
      check($sformatf("done@%0d", i), done, c.d);
      if (i == stop_at) begin
        @(posedge clk); #1;
        reset      = 1'b0;
        stop       = 1'b0;
        start      = 1'b0;
        data_valid = 1'b0;
        #1;
        check("abort_ear", ear, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", data_ready, 1'b0);
        check("abort_done", done, 1'b0);
        break;
      end
    end
    if (!chain) start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  nb, stop_at;
    bit  chained, use_rst, noise;

    reset = 1'b1; start = 1'b1; stop = 1'b0;
    data = 8'h5A; data_valid = 1'b1; data_last = 1'b1;
    @(posedge clk); #1;
    check("rst_ear", ear, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", data_ready, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0; start = 1'b0; data_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_ear", ear, 1'b0);

    // Single last byte 0xA5.
    blk_bytes = '{8'hA5}; blk_dly = '{0};
    build(); kick(); run(-1, 0, 0, 0);

    // 0x00 then 0xFF, second byte 10 cycles late: 11-cycle low gap.
    blk_bytes = '{8'h00, 8'hFF}; blk_dly = '{0, 10};
    build(); kick(); run(-1, 0, 0, 0);

    // Abort during bit 3, then a full block again.
    blk_bytes = '{8'h5A}; blk_dly = '{0};
    build(); kick(); run(bit3_idx + 1, 0, 0, 0);
    build(); kick(); run(-1, 0, 0, 0);

    // Start pulses while busy must change nothing.
    blk_bytes = '{8'hA5, 8'h3C}; blk_dly = '{2, 0};
    build(); kick(); run(-1, 0, 1, 0);

    // Back-to-back blocks: start on the done cycle.
    blk_bytes = '{8'h81}; blk_dly = '{0};
    build(); kick(); run(-1, 0, 0, 1);
    blk_bytes = '{8'h7E}; blk_dly = '{1};
    build(); run(-1, 0, 0, 0);

    // Reset in the middle of a block.
    blk_bytes = '{8'hC3, 8'h18}; blk_dly = '{0, 3};
    build(); kick(); run(40, 1, 0, 0);

    // Randomized blocks.
    chained = 1'b0;
    for (int t = 0; t < 12; t++) begin
      nb = $urandom_range(1, 3);
      blk_bytes.delete(); blk_dly.delete();
      for (int j = 0; j < nb; j++) begin
        blk_bytes.push_back(8'($urandom));
        blk_dly.push_back($urandom_range(0, 4));
      end
      build();
      stop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, tl.size() - 2) : -1;
      use_rst = 1'($urandom_range(0, 1));
      noise   = 1'($urandom_range(0, 1));
      if (!chained) kick();
      chained = (stop_at < 0) && ($urandom_range(0, 1) == 1);
      run(stop_at, use_rst, noise, chained);
    end
    if (chained) begin
      blk_bytes = '{8'hE7}; blk_dly = '{0};
      build(); run(-1, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
